// File: rtl/led_pattern_counter_pkg.sv
// Shared constants and helpers for the LED pattern counter: display mode codes,
// bounce direction and a constant-width helper.
package led_counter_pkg;

  localparam logic [1:0] MODE_UP     = 2'd0;
  localparam logic [1:0] MODE_DOWN   = 2'd1;
  localparam logic [1:0] MODE_GRAY   = 2'd2;
  localparam logic [1:0] MODE_BOUNCE = 2'd3;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  // Bits needed to hold the values 0..value-1; only evaluated at elaboration.
  function automatic int clog2(input int unsigned value);
    int result;
    result = 0;
    for (int i = 0; i < 32; i++) begin
      if (((value - 1) >> i) != 0) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/led_pattern_counter_if.sv
// Control and display bundle between the board-side logic (master) and the
// LED pattern counter (slave).
interface led_pattern_counter_if #(parameter int WIDTH = 8);

  logic             run;
  logic [1:0]       mode;
  logic [1:0]       speed;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] leds;
  logic             tick;
  logic             wrap;

  modport master (output run, mode, speed, load, load_val,
                  input  leds, tick, wrap);

  modport slave  (input  run, mode, speed, load, load_val,
                  output leds, tick, wrap);

endinterface

// File: rtl/led_pattern_counter_tick_gen.sv
// Step-rate generator: a DIV-cycle prescaler feeding a 3-bit sub-counter that
// emits one step every 2^speed base ticks. Both freeze while run is low.
module led_tick_gen
  import led_counter_pkg::*;
#(
  parameter int CLK_FREQ = 25_000_000,
  parameter int TICK_HZ  = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  input  logic [1:0] speed,
  input  logic       clr,
  output logic       step
);

  localparam int DIV = CLK_FREQ / TICK_HZ;
  localparam int PW  = (clog2(DIV) < 1) ? 1 : clog2(DIV);
  localparam logic [PW-1:0] PRESC_MAX = PW'(DIV - 1);

  logic [PW-1:0] presc_q, presc_d;
  logic [2:0]    sub_q, sub_d;
  logic [2:0]    sub_limit;
  logic          base_tick;

  // Using >= means a speed lowered below the current sub count steps at the
  // very next base tick instead of waiting for the 3-bit counter to roll over.
  always_comb begin
    sub_limit = 3'((4'd1 << speed) - 4'd1);
    base_tick = run && (presc_q == PRESC_MAX);
    step      = base_tick && (sub_q >= sub_limit) && !clr;
    presc_d   = presc_q;
    sub_d     = sub_q;
    if (clr) begin
      presc_d = '0;
      sub_d   = '0;
    end else if (base_tick) begin
      presc_d = '0;
      sub_d   = (sub_q >= sub_limit) ? 3'd0 : sub_q + 3'd1;
    end else if (run) begin
      presc_d = presc_q + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
      sub_q   <= '0;
    end else begin
      presc_q <= presc_d;
      sub_q   <= sub_d;
    end
  end

endmodule

// File: rtl/led_pattern_counter.sv
// LED counter/pattern generator: binary up/down, Gray and one-hot bounce
// displays stepped at a programmable rate, with run/pause and parallel load.
module led_pattern_counter
  import led_counter_pkg::*;
#(
  parameter int CLK_FREQ = 25_000_000,
  parameter int TICK_HZ  = 1,
  parameter int WIDTH    = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  led_pattern_counter_if.slave bus
);

  localparam int PW = (clog2(WIDTH) < 1) ? 1 : clog2(WIDTH);
  localparam logic [PW-1:0] POS_MAX = PW'(WIDTH - 1);

  logic             step;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] leds_q, leds_d;
  logic [PW-1:0]    pos_q, pos_d;
  dir_e             dir_q, dir_d;
  logic             tick_q, tick_d;
  logic             wrap_q, wrap_d;

  led_tick_gen #(
    .CLK_FREQ (CLK_FREQ),
    .TICK_HZ  (TICK_HZ)
  ) u_tick_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .run   (bus.run),
    .speed (bus.speed),
    .clr   (bus.load),
    .step  (step)
  );

  // cnt and pos are kept independently so switching modes never loses either.
  always_comb begin
    cnt_d  = cnt_q;
    pos_d  = pos_q;
    dir_d  = dir_q;
    tick_d = 1'b0;
    wrap_d = 1'b0;
    if (bus.load) begin
      cnt_d = bus.load_val;
      pos_d = '0;
      dir_d = DIR_UP;
    end else if (step) begin
      tick_d = 1'b1;
      case (bus.mode)
        MODE_DOWN: begin
          wrap_d = (cnt_q == '0);
          cnt_d  = cnt_q - WIDTH'(1);
        end
        MODE_BOUNCE: begin
          if (dir_q == DIR_UP) begin
            if (pos_q == POS_MAX) begin
              dir_d  = DIR_DOWN;
              pos_d  = POS_MAX - PW'(1);
              wrap_d = 1'b1;
            end else begin
              pos_d = pos_q + PW'(1);
            end
          end else begin
            if (pos_q == '0) begin
              dir_d  = DIR_UP;
              pos_d  = PW'(1);
              wrap_d = 1'b1;
            end else begin
              pos_d = pos_q - PW'(1);
            end
          end
        end
        default: begin
          wrap_d = &cnt_q;
          cnt_d  = cnt_q + WIDTH'(1);
        end
      endcase
    end
  end

  // Display is built from the next state so leds change on the same edge as tick/wrap.
  always_comb begin
    case (bus.mode)
      MODE_GRAY:   leds_d = cnt_d ^ (cnt_d >> 1);
      MODE_BOUNCE: leds_d = WIDTH'(1) << pos_d;
      default:     leds_d = cnt_d;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      pos_q  <= '0;
      dir_q  <= DIR_UP;
      leds_q <= '0;
      tick_q <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      pos_q  <= pos_d;
      dir_q  <= dir_d;
      leds_q <= leds_d;
      tick_q <= tick_d;
      wrap_q <= wrap_d;
    end
  end

  assign bus.leds = leds_q;
  assign bus.tick = tick_q;
  assign bus.wrap = wrap_q;

endmodule

// File: tb/tb_led_pattern_counter.sv
// Bench for led_pattern_counter: directed mode/rate/load/reset scenarios plus a
// random run/mode/speed/load stream, all checked every cycle against a reference model.
module tb_led_pattern_counter;
  import led_counter_pkg::*;

  localparam int CLK_FREQ = 8;
  localparam int TICK_HZ  = 2;
  localparam int WIDTH    = 4;
  localparam int DIV      = CLK_FREQ / TICK_HZ;
  localparam int NVAL     = 1 << WIDTH;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  int total = 0;
  int bad   = 0;

  // Reference model: cycles of run since the last step/load, counter value,
  // bounce position/direction and the expected registered outputs.
  int m_runc, m_cnt, m_pos, m_leds;
  bit m_up, m_tick, m_wrap;

  int w;
  int cur_mode, cur_speed;
  logic [WIDTH-1:0] prev_leds;
  int gray_exp[8]   = '{1, 3, 2, 6, 7, 5, 4, 12};
  int bounce_exp[7] = '{2, 4, 8, 4, 2, 1, 2};
  int bounce_wrp[7] = '{0, 0, 0, 1, 0, 0, 1};

  always #5 clk = ~clk;

  led_pattern_counter_if #(.WIDTH(WIDTH)) bus ();

  led_pattern_counter #(
    .CLK_FREQ (CLK_FREQ),
    .TICK_HZ  (TICK_HZ),
    .WIDTH    (WIDTH)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  function automatic int display(input int mode, input int cnt, input int pos);
    case (mode)
      2:       return cnt ^ (cnt >> 1);
      3:       return 1 << pos;
      default: return cnt;
    endcase
  endfunction

  task automatic model_reset();
    m_runc = 0; m_cnt = 0; m_pos = 0; m_up = 1'b1;
    m_leds = 0; m_tick = 1'b0; m_wrap = 1'b0;
  endtask

  // One rising edge worth of behaviour, from the inputs currently applied.
  task automatic model_clock();
    bit stp;
    stp    = 1'b0;
    m_tick = 1'b0;
    m_wrap = 1'b0;
    if (bus.load) begin
      m_cnt = int'(bus.load_val); m_pos = 0; m_up = 1'b1; m_runc = 0;
    end else if (bus.run) begin
      m_runc++;
      if ((m_runc % DIV == 0) && (m_runc / DIV >= (1 << bus.speed))) begin
        stp = 1'b1;
        m_runc = 0;
      end
    end
    if (stp) begin
      m_tick = 1'b1;
      case (int'(bus.mode))
        1: begin
          m_wrap = (m_cnt == 0);
          m_cnt  = (m_cnt + NVAL - 1) % NVAL;
        end
        3: begin
          if (m_up) begin
            if (m_pos == WIDTH - 1) begin m_up = 1'b0; m_pos = WIDTH - 2; m_wrap = 1'b1; end
            else m_pos++;
          end else begin
            if (m_pos == 0) begin m_up = 1'b1; m_pos = 1; m_wrap = 1'b1; end
            else m_pos--;
          end
        end
        default: begin
          m_wrap = (m_cnt == NVAL - 1);
          m_cnt  = (m_cnt + 1) % NVAL;
        end
      endcase
    end
    m_leds = display(int'(bus.mode), m_cnt, m_pos);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input bit run, input int mode, input int speed,
                               input bit load, input int load_val);
    @(negedge clk);
    bus.run      = run;
    bus.mode     = 2'(mode);
    bus.speed    = 2'(speed);
    bus.load     = load;
    bus.load_val = WIDTH'(load_val);
  endtask

  task automatic cycle();
    @(posedge clk);
    if (rst_n) model_clock();
    else       model_reset();
    #1;
    checkOutput("leds", bus.leds, m_leds);
    checkOutput("tick", bus.tick, m_tick);
    checkOutput("wrap", bus.wrap, m_wrap);
  endtask

  task automatic wait_tick(input int budget, output int waited);
    bit got;
    got    = 1'b0;
    waited = 0;
    while (!got && waited < budget) begin
      cycle();
      waited++;
      if (bus.tick === 1'b1) got = 1'b1;
    end
    checkOutput("tick_seen", got, 1);
  endtask

  initial begin
    bus.run = 1'b0; bus.mode = 2'd0; bus.speed = 2'd0; bus.load = 1'b0; bus.load_val = '0;
    model_reset();
    #1;
    checkOutput("rst_leds", bus.leds, 0);
    checkOutput("rst_tick", bus.tick, 0);
    checkOutput("rst_wrap", bus.wrap, 0);
    cycle();
    cycle();

    $display("[TB] binary up, speed 0");
    bus.run = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 17; i++) begin
      wait_tick(16, w);
      checkOutput("up_spacing", w, DIV);
      checkOutput("up_leds", bus.leds, (i + 1) % NVAL);
      checkOutput("up_wrap", bus.wrap, (i == 15) ? 1 : 0);
    end

    $display("[TB] binary down from 0");
    applyStimulus(1, 1, 0, 1, 0);
    cycle();
    applyStimulus(1, 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      wait_tick(16, w);
      checkOutput("down_spacing", w, DIV);
      checkOutput("down_leds", bus.leds, NVAL - 1 - i);
      checkOutput("down_wrap", bus.wrap, (i == 0) ? 1 : 0);
    end

    $display("[TB] gray up");
    applyStimulus(1, 2, 0, 1, 0);
    cycle();
    applyStimulus(1, 2, 0, 0, 0);
    prev_leds = bus.leds;
    for (int i = 0; i < 8; i++) begin
      wait_tick(16, w);
      checkOutput("gray_leds", bus.leds, gray_exp[i]);
      checkOutput("gray_onebit", $countones(bus.leds ^ prev_leds), 1);
      prev_leds = bus.leds;
    end

    $display("[TB] bounce");
    applyStimulus(1, 3, 0, 1, 0);
    cycle();
    checkOutput("bounce_start", bus.leds, 1);
    applyStimulus(1, 3, 0, 0, 0);
    for (int i = 0; i < 7; i++) begin
      wait_tick(16, w);
      checkOutput("bounce_leds", bus.leds, bounce_exp[i]);
      checkOutput("bounce_wrap", bus.wrap, bounce_wrp[i]);
    end

    $display("[TB] speed 2 with pause");
    applyStimulus(1, 0, 2, 1, 0);
    cycle();
    applyStimulus(1, 0, 2, 0, 0);
    wait_tick(40, w);
    checkOutput("speed2_spacing", w, DIV * 4);
    for (int i = 0; i < 5; i++) cycle();
    prev_leds = bus.leds;
    applyStimulus(0, 0, 2, 0, 0);
    for (int i = 0; i < 10; i++) cycle();
    checkOutput("pause_hold", bus.leds, prev_leds);
    applyStimulus(1, 0, 2, 0, 0);
    wait_tick(40, w);
    checkOutput("pause_delay", 5 + 10 + w, DIV * 4 + 10);

    $display("[TB] load on a step cycle");
    applyStimulus(1, 0, 0, 0, 0);
    wait_tick(40, w);
    for (int i = 0; i < DIV - 1; i++) cycle();
    applyStimulus(1, 0, 0, 1, 10);
    cycle();
    checkOutput("load_leds", bus.leds, 10);
    checkOutput("load_tick", bus.tick, 0);
    applyStimulus(1, 0, 0, 0, 0);
    wait_tick(40, w);
    checkOutput("load_restart", w, DIV);
    checkOutput("load_next", bus.leds, 11);

    $display("[TB] random stream");
    cur_mode = 0;
    cur_speed = 0;
    for (int i = 0; i < 800; i++) begin
      bit r, ld;
      if ($urandom_range(0, 19) == 0) cur_mode = $urandom_range(0, 3);
      if ($urandom_range(0, 29) == 0) cur_speed = $urandom_range(0, 3);
      r  = ($urandom_range(0, 9) != 0);
      ld = ($urandom_range(0, 39) == 0);
      applyStimulus(r, cur_mode, cur_speed, ld, $urandom_range(0, NVAL - 1));
      cycle();
    end

    $display("[TB] async reset mid-count");
    applyStimulus(1, 0, 1, 1, 5);
    cycle();
    applyStimulus(1, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) cycle();
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    checkOutput("async_rst_leds", bus.leds, 0);
    checkOutput("async_rst_tick", bus.tick, 0);
    cycle();
    cycle();
    @(negedge clk);
    rst_n = 1'b1;
    wait_tick(40, w);
    checkOutput("rst_first_step", w, DIV * 2);
    checkOutput("rst_first_leds", bus.leds, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "[TB] watchdog");
  end

endmodule
